// File: rtl/keypad_debouncer_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared state encoding and key-vector helpers for the keypad
//               debounce/qualify stage (supports up to 64 keys).
// Revision    : 1.0
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_QUAL = 2'd1,
        HELD       = 2'd2,
        REL_QUAL   = 2'd3
    } kp_state_t;

    localparam int KP_MAX_KEYS = 64;

    typedef logic [KP_MAX_KEYS-1:0] kp_vec_t;
    typedef logic [5:0]             kp_idx_t;

    function automatic logic is_single_hot(input kp_vec_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // OR-reduction of set-bit positions; exact for a one-hot input.
    function automatic kp_idx_t onehot_to_index(input kp_vec_t v);
        kp_idx_t idx;
        idx = '0;
        for (int i = 0; i < KP_MAX_KEYS; i++) begin
            if (v[i]) begin
                idx = idx | kp_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debouncer_if.sv
// ============================================================================
// Module      : keypad_debouncer_if
// Description : Scanner-to-decoder key bus: raw key vector in, qualified key
//               value, index and event pulses out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface keypad_debouncer_if #(
    parameter int N_KEYS = 16
);
    localparam int IW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] keys_pressed;
    logic [N_KEYS-1:0] key_value;
    logic [IW-1:0]     key_index;
    logic              new_key;
    logic              key_release;
    logic              key_repeat;
    logic              key_held;

    modport master (
        output keys_pressed,
        input  key_value,
        input  key_index,
        input  new_key,
        input  key_release,
        input  key_repeat,
        input  key_held
    );

    modport slave (
        input  keys_pressed,
        output key_value,
        output key_index,
        output new_key,
        output key_release,
        output key_repeat,
        output key_held
    );

endinterface

`default_nettype wire

// File: rtl/keypad_debouncer_timer.sv
// ============================================================================
// Module      : debounce_timer
// Description : Saturating up-counter with clear/start/enable; hit_o flags
//               that an enabled count this cycle lands on limit_i.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module debounce_timer #(
    parameter  int MAX = 50,
    localparam int W   = $clog2(MAX + 1)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         clr_i,
    input  wire logic         start_i,
    input  wire logic         en_i,
    input  wire logic [W-1:0] limit_i,
    output logic              hit_o
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = W'(1);
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == (limit_i - 1'b1));

endmodule

`default_nettype wire

// File: rtl/keypad_debouncer.sv
// ============================================================================
// Module      : keypad_debouncer
// Description : Keypad press/release qualification with optional typematic
//               auto-repeat; outputs one-hot key, binary index and pulses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int N_KEYS         = 16,
    parameter int PRESS_CYCLES   = 50,
    parameter int RELEASE_CYCLES = 50,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 5000,
    parameter int REPEAT_PERIOD  = 1000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    keypad_debouncer_if.slave  kp
);

    localparam int IW      = $clog2(N_KEYS);
    localparam int PW      = $clog2(PRESS_CYCLES + 1);
    localparam int LW      = $clog2(RELEASE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REPW    = $clog2(REP_MAX + 1);

    kp_state_t         state_q;
    kp_state_t         state_d;
    logic [N_KEYS-1:0] cand_q;
    logic [N_KEYS-1:0] cand_d;
    logic [N_KEYS-1:0] key_value_q;
    logic [IW-1:0]     key_index_q;
    logic              new_key_q;
    logic              key_release_q;

    logic [N_KEYS-1:0] w_keys;
    logic              w_single_hot;
    logic              w_match;
    logic              w_active;
    logic              w_accept;
    logic              w_release;
    logic              w_press_start;
    logic              w_press_en;
    logic              w_press_clr;
    logic              w_press_hit;
    logic              w_rel_start;
    logic              w_rel_en;
    logic              w_rel_clr;
    logic              w_rel_hit;
    logic              w_rep_en;
    logic              w_rep_clr;
    logic              w_key_repeat;
    logic              w_key_held;

    assign w_keys       = kp.keys_pressed;
    assign w_single_hot = is_single_hot(kp_vec_t'(w_keys));
    assign w_match      = (w_keys == cand_q);
    assign w_active     = |(w_keys & cand_q);

    debounce_timer #(.MAX(PRESS_CYCLES)) u_press_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_press_clr),
        .start_i (w_press_start),
        .en_i    (w_press_en),
        .limit_i (PW'(PRESS_CYCLES)),
        .hit_o   (w_press_hit)
    );

    debounce_timer #(.MAX(RELEASE_CYCLES)) u_rel_timer (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (w_rel_clr),
        .start_i (w_rel_start),
        .en_i    (w_rel_en),
        .limit_i (LW'(RELEASE_CYCLES)),
        .hit_o   (w_rel_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        w_press_start = 1'b0;
        w_press_en    = 1'b0;
        w_press_clr   = 1'b0;
        w_rel_start   = 1'b0;
        w_rel_en      = 1'b0;
        w_rel_clr     = 1'b0;
        w_rep_en      = 1'b0;
        w_rep_clr     = 1'b0;

        case (state_q)
            IDLE: begin
                w_press_clr = 1'b1;
                w_rel_clr   = 1'b1;
                if (w_single_hot) begin
                    cand_d = w_keys;
                    if (PRESS_CYCLES == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_press_clr   = 1'b0;
                        w_press_start = 1'b1;
                        state_d       = PRESS_QUAL;
                    end
                end
            end
            PRESS_QUAL: begin
                if (w_match) begin
                    w_press_en = 1'b1;
                    if (w_press_hit) begin
                        w_accept = 1'b1;
                    end
                end else begin
                    w_press_clr = 1'b1;
                    state_d     = IDLE;
                end
            end
            HELD: begin
                // Extra keys alongside the active one are deliberately ignored.
                if (w_active) begin
                    w_rep_en = 1'b1;
                end else if (RELEASE_CYCLES == 1) begin
                    w_release = 1'b1;
                    state_d   = IDLE;
                end else begin
                    w_rel_start = 1'b1;
                    state_d     = REL_QUAL;
                end
            end
            REL_QUAL: begin
                if (!w_active) begin
                    w_rel_en = 1'b1;
                    if (w_rel_hit) begin
                        w_release = 1'b1;
                        w_rel_clr = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    w_rel_clr = 1'b1;
                    state_d   = HELD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_accept) begin
            w_press_clr = 1'b1;
            w_rep_clr   = 1'b1;
            state_d     = HELD;
        end
    end

    always_comb begin
        w_key_held = (state_q == HELD) || (state_q == REL_QUAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_key_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_value_q   <= '0;
            key_index_q   <= '0;
        end else begin
            new_key_q     <= w_accept;
            key_release_q <= w_release;
            if (w_accept) begin
                key_value_q <= cand_d;
                key_index_q <= IW'(onehot_to_index(kp_vec_t'(cand_d)));
            end
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            logic            first_done_q;
            logic            key_repeat_q;
            logic [REPW-1:0] w_rep_limit;
            logic            w_rep_hit;
            logic            w_rep_fire;

            // First pulse waits the full delay, later pulses use the period.
            assign w_rep_limit = first_done_q ? REPW'(REPEAT_PERIOD) : REPW'(REPEAT_DELAY);
            assign w_rep_fire  = w_rep_en && w_rep_hit;

            debounce_timer #(.MAX(REP_MAX)) u_rep_timer (
                .clk     (clk),
                .reset   (reset),
                .clr_i   (w_rep_clr | w_rep_fire),
                .start_i (1'b0),
                .en_i    (w_rep_en),
                .limit_i (w_rep_limit),
                .hit_o   (w_rep_hit)
            );

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    first_done_q <= 1'b0;
                    key_repeat_q <= 1'b0;
                end else begin
                    key_repeat_q <= w_rep_fire;
                    if (w_rep_clr) begin
                        first_done_q <= 1'b0;
                    end else if (w_rep_fire) begin
                        first_done_q <= 1'b1;
                    end
                end
            end

            assign w_key_repeat = key_repeat_q;
        end else begin : g_no_repeat
            logic w_unused_rep;
            assign w_unused_rep = w_rep_en ^ w_rep_clr;
            assign w_key_repeat = 1'b0;
        end
    endgenerate

    assign kp.key_value   = key_value_q;
    assign kp.key_index   = key_index_q;
    assign kp.new_key     = new_key_q;
    assign kp.key_release = key_release_q;
    assign kp.key_repeat  = w_key_repeat;
    assign kp.key_held    = w_key_held;

endmodule

`default_nettype wire
